// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes (also used by the
// processor controller), FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2
    } alu_state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the processor controller and the ALU.
// Handshake: start is a one-cycle request, honoured only while the ALU is idle
// (busy=0); op/a/b are sampled on that edge only. done is a level that marks
// result as valid and stays high until the next accepted start. A start seen
// while busy=1 is dropped. Optional macro: ALU_DIVZERO_EN adds div_zero.
interface multicycle_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
`ifdef ALU_DIVZERO_EN
    logic             div_zero;
`endif

`ifdef ALU_DIVZERO_EN
    modport master (output start, op, a, b, input result, done, busy, div_zero);
    modport slave  (input start, op, a, b, output result, done, busy, div_zero);
`else
    modport master (output start, op, a, b, input result, done, busy);
    modport slave  (input start, op, a, b, output result, done, busy);
`endif

endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned magnitude datapath: MSB-first shift-add multiply and
// restoring shift-subtract divide, one bit per enabled cycle.
module seq_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] value,
    output logic             last
);
    localparam int CW = $clog2(WIDTH) + 1;

    // MUL: truncated partial product. DIV: partial remainder.
    logic [WIDTH-1:0] acc;
    // MUL: multiplier bits consumed MSB-first. DIV: dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0] shreg;
    // MUL: multiplicand. DIV: divisor.
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    count;
    logic             div_mode;
    logic [WIDTH:0]   rem_sh;

    assign rem_sh = {acc, shreg[WIDTH-1]};
    assign value  = div_mode ? shreg : acc;
    assign last   = step && (count == CW'(WIDTH - 1));

    // Load operands on an accepted MUL/DIV, then perform one step per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            count    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= is_div;
            opnd     <= is_div ? mag_b : mag_a;
            shreg    <= is_div ? mag_a : mag_b;
            acc      <= '0;
            count    <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (div_mode) begin
                // The remainder always stays below the divisor, so the low WIDTH bits suffice.
                if (rem_sh >= {1'b0, opnd}) begin
                    acc   <= rem_sh[WIDTH-1:0] - opnd;
                    shreg <= {shreg[WIDTH-2:0], 1'b1};
                end else begin
                    acc   <= rem_sh[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc   <= {acc[WIDTH-2:0], 1'b0} + (opnd & {WIDTH{shreg[WIDTH-1]}});
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execution unit behind the processor controller. ADD/SUB (and reserved
// opcodes, treated as ADD) finish in one cycle; MUL/DIV iterate WIDTH steps
// on magnitudes, then a FIXUP cycle applies the sign. Optional macro:
// ALU_DIVZERO_EN adds the div_zero flag and saturating divide-by-zero results.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_alu_if.slave  bus,
    output alu_state_t       state
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] result_r;
    logic             done_r;
    logic             busy_r;
    logic             neg_r;
    logic             dz_r;
`ifdef ALU_DIVZERO_EN
    logic             a_neg_r;
    logic             div_zero_r;
`endif

    logic             is_muldiv;
    logic             core_load;
    logic             core_step;
    logic             core_last;
    logic [WIDTH-1:0] core_value;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fixed;

    assign is_muldiv = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign core_load = (state == ST_IDLE) && bus.start && is_muldiv;
    assign core_step = (state == ST_ITER);
    assign mag_a     = bus.a[WIDTH-1] ? (~bus.a + ONE) : bus.a;
    assign mag_b     = bus.b[WIDTH-1] ? (~bus.b + ONE) : bus.b;

    assign bus.result = result_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
`ifdef ALU_DIVZERO_EN
    assign bus.div_zero = div_zero_r;
`endif

    seq_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .is_div (bus.op == OP_DIV),
        .step   (core_step),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .value  (core_value),
        .last   (core_last)
    );

    // Sign fixup of the magnitude result, with the divide-by-zero override.
    always_comb begin
        fixed = neg_r ? (~core_value + ONE) : core_value;
        if (dz_r) begin
`ifdef ALU_DIVZERO_EN
            fixed = a_neg_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
            fixed = '1;
`endif
        end
    end

    // Control FSM with registered result/done/busy; start is ignored outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            neg_r    <= 1'b0;
            dz_r     <= 1'b0;
`ifdef ALU_DIVZERO_EN
            a_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
`ifdef ALU_DIVZERO_EN
                        div_zero_r <= 1'b0;
                        a_neg_r    <= bus.a[WIDTH-1];
`endif
                        if (is_muldiv) begin
                            neg_r  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            dz_r   <= (bus.op == OP_DIV) && (bus.b == '0);
                            done_r <= 1'b0;
                            busy_r <= 1'b1;
                            state  <= ST_ITER;
                        end else begin
                            result_r <= (bus.op == OP_SUB) ? (bus.a - bus.b) : (bus.a + bus.b);
                            done_r   <= 1'b1;
                        end
                    end
                end
                ST_ITER: begin
                    if (core_last) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result_r <= fixed;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
`ifdef ALU_DIVZERO_EN
                    div_zero_r <= dz_r;
`endif
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
